// File: rtl/adma_pkg.sv
// Shared types and constants for the ADMA host interface blocks.
package adma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } adma_state_e;

    localparam logic DIR_RAM2FIFO = 1'b1;
    localparam logic DIR_FIFO2RAM = 1'b0;

endpackage

// File: rtl/adma_stall_timer.sv
// Counts consecutive enabled cycles and flags the cycle that reaches LIMIT.
// LIMIT = 0 disables the flag entirely.
module adma_stall_timer #(
    parameter int LIMIT = 1024
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] count;

    // The hit fires during the LIMIT-th enabled cycle, not one cycle later.
    assign limit_hit = (LIMIT != 0) && enable && (count == LAST);

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (enable && !limit_hit) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/adma_xfer_engine.sv
// RAM<->FIFO data mover: one DATA_W beat per cycle, pauses on FIFO/RAM
// back-pressure, with alignment check, stall timeout, abort and a TFC pulse.
module adma_xfer_engine
    import adma_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 64,
    parameter int LEN_W       = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic              direction,
    input  logic [ADDR_W-1:0] address_init,
    input  logic [LEN_W-1:0]  length,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] data_from_ram,
    input  logic [DATA_W-1:0] data_from_fifo,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] data_to_ram,
    output logic              fifo_read,
    output logic              fifo_write,
    output logic [DATA_W-1:0] data_to_fifo,
    output logic              busy,
    output logic              TFC,
    output logic              error,
    output adma_state_e       dbg_state
);

    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int REM_W      = LEN_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BEAT_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BEAT_BYTES);
    localparam logic [REM_W-1:0]  REM_MASK  = REM_W'(BEAT_BYTES - 1);
    localparam logic [REM_W-1:0]  REM_STEP  = REM_W'(BEAT_BYTES);

    adma_state_e       state, state_next;
    logic              dir_q;
    logic [ADDR_W-1:0] addr_q;
    logic [REM_W-1:0]  rem_q;
    logic              error_q;
    logic              in_xfer, beat, stall_hit, misaligned, last_beat, accept;

    // Handshake: a beat completes in a cycle where the RAM side (ram_ready) and
    // the FIFO side (!fifo_full for pushes, !fifo_empty for pops) are both ready;
    // strobes assert only in such a cycle, so every strobe is a completed beat.
    assign accept     = (state == IDLE) && start && !abort;
    assign in_xfer    = (state == XFER) && !abort;
    assign beat       = in_xfer && ram_ready &&
                        ((dir_q == DIR_RAM2FIFO) ? !fifo_full : !fifo_empty);
    assign misaligned = ((addr_q & ADDR_MASK) != '0) || ((rem_q & REM_MASK) != '0);
    assign last_beat  = (rem_q == REM_STEP);

    adma_stall_timer #(.LIMIT(STALL_LIMIT)) u_stall_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (!in_xfer || beat),
        .enable   (in_xfer && !beat),
        .limit_hit(stall_hit)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = CHECK;
            CHECK:   state_next = (abort || misaligned) ? IDLE : XFER;
            XFER: begin
                if (abort || stall_hit)    state_next = IDLE;
                else if (beat && last_beat) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            dir_q   <= DIR_FIFO2RAM;
            addr_q  <= '0;
            rem_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                dir_q   <= direction;
                addr_q  <= address_init;
                rem_q   <= (length == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, length};
                error_q <= 1'b0;
            end
            if ((state == CHECK) && !abort && misaligned) error_q <= 1'b1;
            if (stall_hit) error_q <= 1'b1;
            if (beat) begin
                addr_q <= addr_q + ADDR_STEP;
                rem_q  <= rem_q - REM_STEP;
            end
        end
    end

    assign ram_read     = beat && (dir_q == DIR_RAM2FIFO);
    assign fifo_write   = beat && (dir_q == DIR_RAM2FIFO);
    assign fifo_read    = beat && (dir_q == DIR_FIFO2RAM);
    assign ram_write    = beat && (dir_q == DIR_FIFO2RAM);
    assign data_to_fifo = (in_xfer && dir_q == DIR_RAM2FIFO) ? data_from_ram  : '0;
    assign data_to_ram  = (in_xfer && dir_q == DIR_FIFO2RAM) ? data_from_fifo : '0;
    assign ram_address  = addr_q;
    assign busy         = (state == CHECK) || (state == XFER);
    assign TFC          = (state == DONE) && !abort;
    assign error        = error_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_adma_xfer_engine.sv
// Directed bench for adma_xfer_engine: a main 32-bit instance, a 32-bit
// instance with a short stall limit, and a 64-bit instance for the full-length case.
module tb_adma_xfer_engine;
    import adma_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET, start, start_t, start_w, abort, direction;
    logic [63:0] address_init;
    logic [15:0] length;
    logic        ram_ready, fifo_empty, fifo_full;
    logic [31:0] data_from_ram, data_from_fifo;
    logic [63:0] data_from_ram_w, data_from_fifo_w;
    int          fifo_idx;

    logic        m_rr, m_rw, m_fr, m_fw, m_busy, m_tfc, m_err;
    logic [63:0] m_addr;
    logic [31:0] m_dtr, m_dtf;
    adma_state_e m_state;
    logic        t_rr, t_rw, t_fr, t_fw, t_busy, t_tfc, t_err;
    logic [63:0] t_addr;
    logic [31:0] t_dtr, t_dtf;
    adma_state_e t_state;
    logic        w_rr, w_rw, w_fr, w_fw, w_busy, w_tfc, w_err;
    logic [63:0] w_addr, w_dtr, w_dtf;
    adma_state_e w_state;

    assign data_from_ram    = m_addr[31:0] ^ 32'h5A5A_0000;
    assign data_from_fifo   = 32'hC0DE_0000 + 32'(fifo_idx);
    assign data_from_ram_w  = 64'h1122_3344_5566_7788;
    assign data_from_fifo_w = 64'h0;

    adma_xfer_engine #(.DATA_W(32), .STALL_LIMIT(16)) u_dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort), .direction(direction),
        .address_init(address_init), .length(length), .ram_ready(ram_ready),
        .data_from_ram(data_from_ram), .data_from_fifo(data_from_fifo),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .ram_read(m_rr), .ram_write(m_rw), .ram_address(m_addr), .data_to_ram(m_dtr),
        .fifo_read(m_fr), .fifo_write(m_fw), .data_to_fifo(m_dtf),
        .busy(m_busy), .TFC(m_tfc), .error(m_err), .dbg_state(m_state)
    );

    adma_xfer_engine #(.DATA_W(32), .STALL_LIMIT(4)) u_dut_t (
        .CLK(CLK), .RESET(RESET), .start(start_t), .abort(abort), .direction(direction),
        .address_init(address_init), .length(length), .ram_ready(ram_ready),
        .data_from_ram(data_from_ram), .data_from_fifo(data_from_fifo),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .ram_read(t_rr), .ram_write(t_rw), .ram_address(t_addr), .data_to_ram(t_dtr),
        .fifo_read(t_fr), .fifo_write(t_fw), .data_to_fifo(t_dtf),
        .busy(t_busy), .TFC(t_tfc), .error(t_err), .dbg_state(t_state)
    );

    adma_xfer_engine #(.DATA_W(64)) u_dut_w (
        .CLK(CLK), .RESET(RESET), .start(start_w), .abort(abort), .direction(direction),
        .address_init(address_init), .length(length), .ram_ready(ram_ready),
        .data_from_ram(data_from_ram_w), .data_from_fifo(data_from_fifo_w),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .ram_read(w_rr), .ram_write(w_rw), .ram_address(w_addr), .data_to_ram(w_dtr),
        .fifo_read(w_fr), .fifo_write(w_fw), .data_to_fifo(w_dtf),
        .busy(w_busy), .TFC(w_tfc), .error(w_err), .dbg_state(w_state)
    );

    // Observation mux: sel 0 = main, 1 = short-timeout, 2 = 64-bit instance.
    int          sel;
    logic        o_rr, o_rw, o_fr, o_fw, o_busy, o_tfc, o_err;
    logic [63:0] o_addr;
    logic [31:0] o_dtr, o_dtf;
    adma_state_e o_state;

    always_comb begin
        {o_rr, o_rw, o_fr, o_fw, o_busy, o_tfc, o_err} = {m_rr, m_rw, m_fr, m_fw, m_busy, m_tfc, m_err};
        o_addr = m_addr; o_dtr = m_dtr; o_dtf = m_dtf; o_state = m_state;
        if (sel == 1) begin
            {o_rr, o_rw, o_fr, o_fw, o_busy, o_tfc, o_err} = {t_rr, t_rw, t_fr, t_fw, t_busy, t_tfc, t_err};
            o_addr = t_addr; o_dtr = t_dtr; o_dtf = t_dtf; o_state = t_state;
        end else if (sel == 2) begin
            {o_rr, o_rw, o_fr, o_fw, o_busy, o_tfc, o_err} = {w_rr, w_rw, w_fr, w_fw, w_busy, w_tfc, w_err};
            o_addr = w_addr; o_dtr = w_dtr[31:0]; o_dtf = w_dtf[31:0]; o_state = w_state;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_addr_q[$];
    logic [31:0] obs_data_q[$];
    int w_beats, w_first, w_last, w_tfc_cyc, w_tfc_cnt, w_idle_cyc, w_bad, w_busy_tfc;

    // All driving happens 1 time unit after a rising edge; sampling 1 unit later.
    task automatic start_xfer(input int s, input logic d, input logic [63:0] a, input logic [15:0] l);
        sel = s; direction = d; address_init = a; length = l;
        start = (s == 0); start_t = (s == 1); start_w = (s == 2);
        @(posedge CLK); #1;
        start = 1'b0; start_t = 1'b0; start_w = 1'b0;
    endtask

    task automatic watch(input int max_cyc, input int stall_from, input int stall_len, input int abort_at);
        logic fr_seen;
        w_beats = 0; w_first = -1; w_last = -1; w_tfc_cyc = -1; w_tfc_cnt = 0;
        w_idle_cyc = -1; w_bad = 0; w_busy_tfc = 0;
        obs_addr_q.delete(); obs_data_q.delete();
        for (int c = 0; c < max_cyc; c++) begin
            if (c >= stall_from && c < stall_from + stall_len) begin
                fifo_full = direction; fifo_empty = !direction;
            end else begin
                fifo_full = 1'b0; fifo_empty = 1'b0;
            end
            abort = (c == abort_at);
            #1;
            if (o_state == IDLE) begin
                w_idle_cyc = c;
                break;
            end
            if (direction ? (o_rr || o_fw) : (o_fr || o_rw)) begin
                w_beats++;
                if (w_first < 0) w_first = c;
                w_last = c;
                obs_addr_q.push_back(o_addr);
                obs_data_q.push_back(direction ? o_dtf : o_dtr);
            end
            if (direction) begin
                if (o_rr !== o_fw || o_fr || o_rw || o_dtr !== 32'h0) w_bad++;
            end else begin
                if (o_fr !== o_rw || o_rr || o_fw || o_dtf !== 32'h0) w_bad++;
            end
            if (o_tfc) begin
                w_tfc_cnt++; w_tfc_cyc = c;
                if (o_busy) w_busy_tfc++;
            end
            fr_seen = o_fr;
            @(posedge CLK); #1;
            if (fr_seen) fifo_idx++;
        end
        abort = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0;
        start = 1'b0; start_t = 1'b0; start_w = 1'b0;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({m_rr, m_rw, m_fr, m_fw, m_busy, m_tfc, m_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 0000000", {m_rr, m_rw, m_fr, m_fw, m_busy, m_tfc, m_err});
        end
        n_tests++;
        if (m_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %0h exp 0", m_addr); end
        n_tests++;
        if ({m_dtr, m_dtf} !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %0h exp 0", {m_dtr, m_dtf}); end
        n_tests++;
        if (m_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", m_state, IDLE); end
    endtask

    task automatic test_ram2fifo;
        logic [63:0] e;
        start_xfer(0, 1'b1, 64'h1000, 16'd16);
        watch(20, -1, 0, -1);
        n_tests++;
        if (w_beats !== 4 || w_first !== 1 || w_last !== 4) begin
            n_fail++; $display("FAIL r2f_beats: got %0d beats at %0d..%0d exp 4 at 1..4", w_beats, w_first, w_last);
        end
        n_tests++;
        if (w_tfc_cyc !== 5 || w_tfc_cnt !== 1 || w_busy_tfc !== 0) begin
            n_fail++; $display("FAIL r2f_tfc: got cyc %0d cnt %0d busy %0d exp cyc 5 cnt 1 busy 0", w_tfc_cyc, w_tfc_cnt, w_busy_tfc);
        end
        n_tests++;
        if (w_idle_cyc !== 6 || m_err !== 1'b0 || w_bad !== 0) begin
            n_fail++; $display("FAIL r2f_end: got idle %0d err %b bad %0d exp idle 6 err 0 bad 0", w_idle_cyc, m_err, w_bad);
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(64'h1000 + 64'(4 * k));
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_addr_q[k] !== e || obs_data_q[k] !== (e[31:0] ^ 32'h5A5A_0000)) begin
                n_fail++; $display("FAIL r2f_beat%0d: got addr %0h data %0h exp addr %0h data %0h",
                                   k, obs_addr_q[k], obs_data_q[k], e, e[31:0] ^ 32'h5A5A_0000);
            end
        end
    endtask

    task automatic test_fifo2ram_stall;
        fifo_idx = 0;
        start_xfer(0, 1'b0, 64'h2000, 16'd8);
        watch(30, 2, 5, -1);
        n_tests++;
        if (w_beats !== 2 || w_first !== 1 || w_last !== 7) begin
            n_fail++; $display("FAIL f2r_beats: got %0d beats at %0d..%0d exp 2 at 1..7", w_beats, w_first, w_last);
        end
        n_tests++;
        if (obs_addr_q[0] !== 64'h2000 || obs_addr_q[1] !== 64'h2004) begin
            n_fail++; $display("FAIL f2r_addr: got %0h %0h exp 2000 2004", obs_addr_q[0], obs_addr_q[1]);
        end
        n_tests++;
        if (obs_data_q[0] !== 32'hC0DE_0000 || obs_data_q[1] !== 32'hC0DE_0001) begin
            n_fail++; $display("FAIL f2r_data: got %0h %0h exp c0de0000 c0de0001", obs_data_q[0], obs_data_q[1]);
        end
        n_tests++;
        if (w_tfc_cyc !== 8 || w_tfc_cnt !== 1 || m_err !== 1'b0 || w_bad !== 0 || m_addr !== 64'h2008) begin
            n_fail++; $display("FAIL f2r_end: got tfc %0d cnt %0d err %b bad %0d addr %0h exp 8 1 0 0 2008",
                               w_tfc_cyc, w_tfc_cnt, m_err, w_bad, m_addr);
        end
    endtask

    task automatic test_fifo_full_pause;
        start_xfer(0, 1'b1, 64'h3000, 16'd12);
        watch(20, 2, 2, -1);
        n_tests++;
        if (w_beats !== 3 || w_last !== 5 || w_tfc_cyc !== 6 || obs_addr_q[2] !== 64'h3008) begin
            n_fail++; $display("FAIL pause: got beats %0d last %0d tfc %0d addr2 %0h exp 3 5 6 3008",
                               w_beats, w_last, w_tfc_cyc, obs_addr_q[2]);
        end
    endtask

    task automatic test_misaligned;
        logic [63:0] addrs[2];
        logic [15:0] lens[2];
        addrs[0] = 64'h1002; lens[0] = 16'd16;
        addrs[1] = 64'h1000; lens[1] = 16'd6;
        for (int k = 0; k < 2; k++) begin
            start_xfer(0, 1'b1, addrs[k], lens[k]);
            watch(10, -1, 0, -1);
            n_tests++;
            if (w_idle_cyc !== 1 || w_beats !== 0 || w_tfc_cnt !== 0 || m_err !== 1'b1 || w_bad !== 0) begin
                n_fail++; $display("FAIL misalign%0d: got idle %0d beats %0d tfc %0d err %b exp 1 0 0 1",
                                   k, w_idle_cyc, w_beats, w_tfc_cnt, m_err);
            end
        end
        start_xfer(0, 1'b1, 64'h1000, 16'd8);
        n_tests++;
        if (m_err !== 1'b0 || m_busy !== 1'b1) begin
            n_fail++; $display("FAIL err_clear: got err %b busy %b exp err 0 busy 1", m_err, m_busy);
        end
        watch(10, -1, 0, -1);
        n_tests++;
        if (w_beats !== 2 || w_tfc_cnt !== 1 || m_err !== 1'b0) begin
            n_fail++; $display("FAIL after_err: got beats %0d tfc %0d err %b exp 2 1 0", w_beats, w_tfc_cnt, m_err);
        end
    endtask

    task automatic test_timeout;
        start_xfer(1, 1'b1, 64'h4000, 16'd16);
        watch(20, 0, 100, -1);
        n_tests++;
        if (w_idle_cyc !== 5 || w_beats !== 0 || w_tfc_cnt !== 0 || t_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout: got idle %0d beats %0d tfc %0d err %b exp 5 0 0 1",
                               w_idle_cyc, w_beats, w_tfc_cnt, t_err);
        end
        sel = 0;
    endtask

    task automatic test_abort;
        start_xfer(0, 1'b1, 64'h1000, 16'd16);
        address_init = 64'h9000;
        start = 1'b1;
        watch(20, -1, 0, 2);
        n_tests++;
        if (w_beats !== 1 || obs_addr_q[0] !== 64'h1000 || w_idle_cyc !== 3) begin
            n_fail++; $display("FAIL abort_beats: got beats %0d addr %0h idle %0d exp 1 1000 3",
                               w_beats, obs_addr_q[0], w_idle_cyc);
        end
        n_tests++;
        if (w_tfc_cnt !== 0 || m_err !== 1'b0 || m_busy !== 1'b0 || m_addr !== 64'h1004) begin
            n_fail++; $display("FAIL abort_end: got tfc %0d err %b busy %b addr %0h exp 0 0 0 1004",
                               w_tfc_cnt, m_err, m_busy, m_addr);
        end
        start = 1'b1; abort = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; abort = 1'b0;
        n_tests++;
        if (m_state !== IDLE || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL start_abort: got state %0d busy %b exp %0d 0", m_state, m_busy, IDLE);
        end
    endtask

    task automatic test_wrap;
        start_xfer(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 16'd8);
        watch(10, -1, 0, -1);
        n_tests++;
        if (w_beats !== 2 || obs_addr_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || obs_addr_q[1] !== 64'h0 ||
            w_tfc_cnt !== 1 || m_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap: got beats %0d addr %0h %0h tfc %0d err %b exp 2 fffffffffffffffc 0 1 0",
                               w_beats, obs_addr_q[0], obs_addr_q[1], w_tfc_cnt, m_err);
        end
    endtask

    task automatic test_reset_mid;
        start_xfer(0, 1'b1, 64'h5000, 16'd16);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        n_tests++;
        if (m_state !== IDLE || m_addr !== 64'h0 ||
            {m_rr, m_rw, m_fr, m_fw, m_busy, m_tfc, m_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_mid: got state %0d addr %0h flags %b exp %0d 0 0000000",
                               m_state, m_addr, {m_rr, m_rw, m_fr, m_fw, m_busy, m_tfc, m_err}, IDLE);
        end
        @(posedge CLK); #1;
        n_tests++;
        if (m_tfc !== 1'b0 || m_state !== IDLE) begin
            n_fail++; $display("FAIL reset_mid_tfc: got tfc %b state %0d exp 0 %0d", m_tfc, m_state, IDLE);
        end
    endtask

    task automatic test_len0_w64;
        start_xfer(2, 1'b1, 64'h0, 16'd0);
        watch(8300, -1, 0, -1);
        n_tests++;
        if (w_beats !== 8192 || w_first !== 1 || w_last !== 8192) begin
            n_fail++; $display("FAIL len0_beats: got %0d at %0d..%0d exp 8192 at 1..8192", w_beats, w_first, w_last);
        end
        n_tests++;
        if (w_tfc_cyc !== 8193 || w_tfc_cnt !== 1 || w_err !== 1'b0 || w_addr !== 64'h1_0000) begin
            n_fail++; $display("FAIL len0_end: got tfc %0d cnt %0d err %b addr %0h exp 8193 1 0 10000",
                               w_tfc_cyc, w_tfc_cnt, w_err, w_addr);
        end
        n_tests++;
        if (obs_addr_q[8191] !== 64'hFFF8 || obs_data_q[0] !== 32'h5566_7788 || w_bad !== 0) begin
            n_fail++; $display("FAIL len0_data: got last addr %0h data %0h bad %0d exp fff8 55667788 0",
                               obs_addr_q[8191], obs_data_q[0], w_bad);
        end
        sel = 0;
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; start_t = 1'b0; start_w = 1'b0; abort = 1'b0;
        direction = 1'b0; address_init = '0; length = '0;
        ram_ready = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b0;
        fifo_idx = 0; sel = 0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        RESET = 1'b0;
        @(posedge CLK); #1;
        test_ram2fifo();
        test_fifo2ram_stall();
        test_fifo_full_pause();
        test_misaligned();
        test_timeout();
        test_abort();
        test_wrap();
        test_reset_mid();
        test_len0_w64();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
